alu_op_scheduler: RTL

//   Shares one registered ALU (opcodes Sel 000..101; R and Zflag update on posedge CLK) between two requesters.

---
 rtl/alu_op_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler that shares one external registered ALU between two
// requesters and returns each result on a valid/ready response channel.
`timescale 1ns/1ps
module alu_op_scheduler #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [2:0]       req0_Sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [2:0]       req1_Sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_R,
    output logic             rsp_Z,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_Sel,
    input  logic [WIDTH-1:0] alu_R,
    input  logic             alu_Zflag,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_last, w_last_nxt;
    logic             r_id, w_id_nxt;
    logic [WIDTH-1:0] r_alu_A, w_alu_A_nxt;
    logic [WIDTH-1:0] r_alu_B, w_alu_B_nxt;
    logic [2:0]       r_alu_Sel, w_alu_Sel_nxt;
    logic             r_rsp_valid, w_rsp_valid_nxt;
    logic [WIDTH-1:0] r_rsp_R, w_rsp_R_nxt;
    logic             r_rsp_Z, w_rsp_Z_nxt;
    logic             r_rsp_err, w_rsp_err_nxt;
    logic             r_busy, w_busy_nxt;

    logic             w_any_valid;
    logic             w_grant;
    logic             w_accept;
    logic [WIDTH-1:0] w_pay_A, w_pay_B;
    logic [2:0]       w_pay_Sel;
    logic             w_illegal;

    // Arbitration: lone requester wins; on a tie the one not served last wins
    assign w_any_valid = req0_valid | req1_valid;
    assign w_grant     = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    assign w_accept    = (r_state == IDLE) & w_any_valid;
    assign req0_ready  = w_accept & ~w_grant;
    assign req1_ready  = w_accept & w_grant;
    assign w_pay_A     = w_grant ? req1_A   : req0_A;
    assign w_pay_B     = w_grant ? req1_B   : req0_B;
    assign w_pay_Sel   = w_grant ? req1_Sel : req0_Sel;
    assign w_illegal   = w_pay_Sel[2] & w_pay_Sel[1];
    assign w_busy_nxt  = (w_state_nxt != IDLE);

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_last_nxt      = r_last;
        w_id_nxt        = r_id;
        w_alu_A_nxt     = r_alu_A;
        w_alu_B_nxt     = r_alu_B;
        w_alu_Sel_nxt   = r_alu_Sel;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_R_nxt     = r_rsp_R;
        w_rsp_Z_nxt     = r_rsp_Z;
        w_rsp_err_nxt   = r_rsp_err;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_id_nxt   = w_grant;
                    w_last_nxt = w_grant;
                    if (w_illegal) begin
                        // Illegal opcode never reaches the ALU
                        w_rsp_R_nxt     = '0;
                        w_rsp_Z_nxt     = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_valid_nxt = 1'b1;
                        w_state_nxt     = RESP;
                    end else begin
                        w_alu_A_nxt   = w_pay_A;
                        w_alu_B_nxt   = w_pay_B;
                        w_alu_Sel_nxt = w_pay_Sel;
                        w_cnt_nxt     = CNT_W'(ALU_LAT);
                        w_state_nxt   = EXEC;
                    end
                end
            end
            EXEC: begin
                if (r_cnt == '0) begin
                    w_rsp_R_nxt     = alu_R;
                    w_rsp_Z_nxt     = alu_Zflag;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_id        <= 1'b0;
            r_alu_A     <= '0;
            r_alu_B     <= '0;
            r_alu_Sel   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_R     <= '0;
            r_rsp_Z     <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_last      <= w_last_nxt;
            r_id        <= w_id_nxt;
            r_alu_A     <= w_alu_A_nxt;
            r_alu_B     <= w_alu_B_nxt;
            r_alu_Sel   <= w_alu_Sel_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_R     <= w_rsp_R_nxt;
            r_rsp_Z     <= w_rsp_Z_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_R     = r_rsp_R;
    assign rsp_Z     = r_rsp_Z;
    assign rsp_err   = r_rsp_err;
    assign alu_A     = r_alu_A;
    assign alu_B     = r_alu_B;
    assign alu_Sel   = r_alu_Sel;
    assign busy      = r_busy;

endmodule
